// File: rtl/key_evt_ctrl.sv
// Key event sequencer: classifies debounced key presses as short/long/repeat with one shared hold timer.
// Define KEY_EVT_REPEAT_EN to enable auto-repeat events; otherwise REPEAT only waits for release.
module key_evt_ctrl #(
  parameter int                N_KEY    = 4,
  parameter int                IDX_W    = 2,
  parameter int                CNT_W    = 26,
  parameter logic [CNT_W-1:0]  T_LONG   = 26'd25_000_000,
  parameter logic [CNT_W-1:0]  T_REPEAT = 26'd5_000_000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_KEY-1:0] key_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_key,
  output logic [1:0]       evt_type,
  output logic             evt_drop,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = T_LONG - 1'b1;

  // Timer terminal counts below 2 would collapse the hold/repeat windows.
  if (T_LONG < 2 || T_REPEAT < 2) begin : g_bad_param
    $error("key_evt_ctrl: T_LONG and T_REPEAT must both be >= 2");
  end

  state_t             state_q, state_d;
  logic [N_KEY-1:0]   key_d1_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0]   evt_key_q, evt_key_d;
  logic [1:0]         evt_type_q, evt_type_d;
  logic               evt_drop_q, evt_drop_d;

  logic [N_KEY-1:0]   press_edge;
  logic [IDX_W-1:0]   first_idx;
  logic               held;
  logic               gen;
  logic [1:0]         gen_type;
  logic               hs;

  assign press_edge = key_in & ~key_d1_q;
  assign held       = |(key_in & ({{(N_KEY-1){1'b0}}, 1'b1} << sel_q));
  assign hs         = evt_valid_q & evt_ready;

  always_comb begin
    first_idx = '0;
    for (int i = N_KEY - 1; i >= 0; i--) begin
      if (press_edge[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    gen      = 1'b0;
    gen_type = 2'b00;
    case (state_q)
      IDLE: begin
        if (|press_edge) begin
          sel_d   = first_idx;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!held) begin
          gen      = 1'b1;
          gen_type = EVT_SHORT;
          state_d  = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          gen      = 1'b1;
          gen_type = EVT_LONG;
          cnt_d    = '0;
          state_d  = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
`ifdef KEY_EVT_REPEAT_EN
        if (!held) begin
          state_d = IDLE;
        end else if (cnt_q == T_REPEAT - 1'b1) begin
          gen      = 1'b1;
          gen_type = EVT_REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        cnt_d = '0;
        if (!held) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // One-entry slot: a generate may refill the slot in the same cycle it is handshaken.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    evt_drop_d  = 1'b0;
    if (gen) begin
      if (!evt_valid_q || hs) begin
        evt_valid_d = 1'b1;
        evt_key_d   = sel_q;
        evt_type_d  = gen_type;
      end else begin
        evt_drop_d = 1'b1;
      end
    end else if (hs) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      key_d1_q    <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= 2'b00;
      evt_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_d1_q    <= key_in;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_type_q  <= evt_type_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_type  = evt_type_q;
  assign evt_drop  = evt_drop_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/key_evt_ctrl.md
Name: key_evt_ctrl

Overview:
Sequencer for the outputs of a bank of per-key debouncers. A single shared hold timer is granted to one key at a time. The block classifies each press as short, long, or auto-repeat and presents events on a one-entry valid/ready output slot. It sits between the debouncers and the application FSMs (menu, counter, LED control).

Parameters:
N_KEY, 4, number of debounced key inputs
IDX_W, 2, width of key index; 2**IDX_W >= N_KEY
CNT_W, 26, width of shared timer
T_LONG, 26'd25_000_000, hold cycles to qualify as long press (0.5 s at 50 MHz); must be >= 2
T_REPEAT, 26'd5_000_000, cycles between repeat events (100 ms); must be >= 2

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
key_in  input  N_KEY  debounced key levels, 1 = pressed
evt_valid  output  1  event slot holds an event
evt_ready  input  1  consumer accepts event when evt_valid=1
evt_key  output  IDX_W  index of key that produced the event
evt_type  output  2  2'b01 short, 2'b10 long, 2'b11 repeat; 2'b00 never presented
evt_drop  output  1  one-cycle pulse: event generated while slot full, event discarded
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (n_rst=0, asynchronous) forces the following:
  - key_d1=0, state=IDLE, cnt=0, sel=0.
  - evt_valid=0, evt_key=0, evt_type=0, evt_drop=0, busy=0.
- Internal signals:
  - key_d1: key_in registered each clk.
  - press_edge = key_in & ~key_d1.
  - sel = captured key index; held = key_in[sel].
- States: IDLE, HOLD, REPEAT. busy = (state != IDLE).
- IDLE:
  - If press_edge != 0: sel <= lowest set bit index, cnt <= 0, go HOLD.
  - Other simultaneous edges are ignored.
- HOLD:
  - If !held: generate SHORT(sel), go IDLE.
  - Else if cnt == T_LONG-1: generate LONG(sel), cnt <= 0, go REPEAT.
  - Else cnt <= cnt+1.
  - LONG appears on evt_valid T_LONG+1 clocks after the key_in rising edge.
- REPEAT:
  - If !held: go IDLE, no event.
  - Else if cnt == T_REPEAT-1: generate REPEAT(sel), cnt <= 0.
  - Else cnt <= cnt+1.
- Keys other than sel are ignored while busy; edges occurring then are lost. A key already held when the FSM returns to IDLE produces nothing until it is released and pressed again.
- Release and new press on the same cycle in HOLD: SHORT is issued; the new edge is not seen in that cycle.
- Event slot:
  - A handshake occurs when evt_valid & evt_ready.
  - On generate with slot empty or handshaking this cycle: load evt_key/evt_type, evt_valid <= 1.
  - On handshake with no generate: evt_valid <= 0.
  - On generate with slot full and no handshake: slot unchanged, evt_drop <= 1 for one cycle.
- evt_key/evt_type are held stable while evt_valid=1 and !evt_ready.
- Event latency: registered, one clock after the generating edge.
- Timer is never compared while in IDLE; cnt wraps never (bounded by T_LONG-1 / T_REPEAT-1).
- Reset mid-operation: everything returns to reset values immediately; a pending event is lost.

Optional Feature:
KEY_EVT_REPEAT_EN
- Defined: REPEAT state generates repeat events as described.
- Undefined: REPEAT state only waits for release; cnt is held at 0 and evt_type 2'b11 is never produced. The T_REPEAT comparator and its logic are not synthesised.

Test Plan:
Use N_KEY=4, T_LONG=8, T_REPEAT=4, evt_ready=1, KEY_EVT_REPEAT_EN defined, unless stated otherwise.
- Short press: key_in[2] high for 5 clocks, then low -> exactly one event, evt_key=2, evt_type=01, one clock after release detected; busy drops to 0.
- Long press with repeat: key_in[1] held 20 clocks -> LONG (key 1, type 10) at clock 9 after the rising edge, then REPEAT (type 11) every 4 clocks until release; no event on release.
- Simultaneous press: key_in 4'b1010 rising together -> sel=1. Key 3 produces no event even when key 1 is released first while key 3 is still held.
- Backpressure: evt_ready=0, short press on key 0, then short press on key 2 -> slot keeps key 0/type 01 and evt_drop pulses once. Raising evt_ready -> one handshake, then evt_valid=0.
- Handshake coincident with generate: REPEAT events with evt_ready toggled so a handshake lands on a generate cycle -> evt_valid stays 1, new event loaded, evt_drop=0.
- Reset mid-hold and macro off: n_rst low during HOLD -> all outputs 0 asynchronously. Rebuild without KEY_EVT_REPEAT_EN and hold 20 clocks -> only LONG, no type 11.
